// File: rtl/secuenciador_notas_if.sv
// Note sequencer bus: serial bytes, buttons and manual
// note in; tone control and status out.
interface secuenciador_notas_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          btn_play;
    logic          btn_stop;
    logic          free_valid;
    logic [2:0]    free_note;
    logic [2:0]    nota_out;
    logic          tono_en;
    logic          contar;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          busy;

    modport master (
        output rx_valid, rx_data, btn_play, btn_stop,
        output free_valid, free_note,
        input  nota_out, tono_en, contar,
        input  fifo_count, overflow, busy
    );

    modport slave (
        input  rx_valid, rx_data, btn_play, btn_stop,
        input  free_valid, free_note,
        output nota_out, tono_en, contar,
        output fifo_count, overflow, busy
    );
endinterface

// File: rtl/secuenciador_notas.sv
// Note sequencer: FIFO of note bytes, timed playback
// with gaps, and a manual note override.
module secuenciador_notas #(
    parameter int TICK_DIV = 50000,
    parameter int NOTE_MS  = 250,
    parameter int GAP_MS   = 50,
    parameter int DEPTH    = 8
) (
    input logic                clk,
    input logic                rst,
    secuenciador_notas_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int PW   = $clog2(TICK_DIV + 1);
    localparam int DMAX = (8 * NOTE_MS > GAP_MS) ? 8 * NOTE_MS : GAP_MS;
    localparam int DW   = $clog2(DMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_MANUAL
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [6:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_play_d;
    logic          r_stop_d;
    logic          r_run;
    logic [PW-1:0] r_pre;
    logic [DW-1:0] r_dur;
    logic [2:0]    r_note;
    logic [2:0]    r_len;
    logic          r_rest;
    logic [2:0]    r_last;
    logic          r_prev_load;
    logic          r_prev_man;

    logic          w_play_edge;
    logic          w_stop_edge;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_abort;
    logic          w_tick;
    logic          w_play_done;
    logic          w_gap_done;
    logic [31:0]   w_play_lim;
    logic [6:0]    w_head;
    logic [2:0]    w_nota;
    logic          w_tono;
    logic          w_contar;

    assign w_play_edge = bus.btn_play & ~r_play_d;
    assign w_stop_edge = bus.btn_stop & ~r_stop_d;
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = bus.rx_valid & ~w_full;
    assign w_pop       = (r_state == S_LOAD) & ~w_empty;
    assign w_abort     = w_stop_edge | ~r_run;
    assign w_head      = r_mem[r_rp];
    assign w_play_lim  = (32'(r_len) + 32'd1) * 32'(NOTE_MS);
    assign w_tick      = (32'(r_pre) == 32'(TICK_DIV - 1));
    assign w_play_done = w_tick & (32'(r_dur) == w_play_lim - 32'd1);
    assign w_gap_done  = w_tick & (32'(r_dur) == 32'(GAP_MS - 1));

    // Button edge registers and run flag; stop beats play.
    always_ff @(posedge clk) begin
        r_play_d <= bus.btn_play;
        r_stop_d <= bus.btn_stop;
        if (rst) begin
            r_run <= 1'b0;
        end else if (w_stop_edge) begin
            r_run <= 1'b0;
        end else if (w_play_edge) begin
            r_run <= 1'b1;
        end
    end

    // FIFO storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= {bus.rx_data[7:4], bus.rx_data[2:0]};
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (bus.rx_valid && w_full) r_ovf <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state; a manual request overrides everything.
    always_comb begin
        w_next = r_state;
        if (bus.free_valid && r_state != S_MANUAL) begin
            w_next = S_MANUAL;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_run && !w_empty) w_next = S_LOAD;
                end
                S_LOAD: begin
                    w_next = w_abort ? S_IDLE : S_PLAY;
                end
                S_PLAY: begin
                    if (w_abort)          w_next = S_IDLE;
                    else if (w_play_done) w_next = S_GAP;
                end
                S_GAP: begin
                    if (w_abort) begin
                        w_next = S_IDLE;
                    end else if (w_gap_done) begin
                        w_next = w_empty ? S_IDLE : S_LOAD;
                    end
                end
                S_MANUAL: begin
                    if (!bus.free_valid) w_next = S_GAP;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Prescaler and time-unit counter, restarted on every state change.
    always_ff @(posedge clk) begin
        if (rst || w_next != r_state) begin
            r_pre <= '0;
            r_dur <= '0;
        end else if (r_state == S_PLAY || r_state == S_GAP) begin
            if (w_tick) begin
                r_pre <= '0;
                r_dur <= r_dur + DW'(1);
            end else begin
                r_pre <= r_pre + PW'(1);
            end
        end
    end

    // Note register loaded from the FIFO head in LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_note <= '0;
            r_len  <= '0;
            r_rest <= 1'b0;
        end else if (r_state == S_LOAD) begin
            r_rest <= w_head[6];
            r_len  <= w_head[5:3];
            r_note <= w_head[2:0];
        end
    end

    // Tone outputs; nota_out holds its last value outside PLAY/MANUAL.
    always_comb begin
        w_nota   = r_last;
        w_tono   = 1'b0;
        w_contar = 1'b0;
        unique case (r_state)
            S_PLAY: begin
                w_nota   = r_note;
                w_tono   = ~r_rest;
                w_contar = r_prev_load & ~r_rest;
            end
            S_MANUAL: begin
                w_nota   = bus.free_note;
                w_tono   = 1'b1;
                w_contar = ~r_prev_man | (bus.free_note != r_last);
            end
            default: ;
        endcase
    end

    // History used for hold and pulse generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last      <= '0;
            r_prev_load <= 1'b0;
            r_prev_man  <= 1'b0;
        end else begin
            r_last      <= w_nota;
            r_prev_load <= (r_state == S_LOAD);
            r_prev_man  <= (r_state == S_MANUAL);
        end
    end

    assign bus.nota_out   = w_nota;
    assign bus.tono_en    = w_tono;
    assign bus.contar     = w_contar;
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_ovf;
    assign bus.busy       = (r_state != S_IDLE);
endmodule
